// File: rtl/acc_req_arbiter_if.sv
// Bundle of requester-side, accelerator-side and status signals shared by
// acc_req_arbiter; slave is the arbiter, master is everything around it.
interface acc_req_arbiter_if #(
    parameter int NrPorts        = 2,
    parameter int InsnWidth      = 32,
    parameter int DataWidth      = 64,
    parameter int TransIdBits    = 3,
    parameter int MaxOutstanding = 4
);
    localparam int CntW = $clog2(MaxOutstanding + 1);

    logic [NrPorts-1:0]             req_valid_i;
    logic [NrPorts-1:0]             req_ready_o;
    logic [NrPorts*InsnWidth-1:0]   req_insn_i;
    logic [NrPorts*DataWidth-1:0]   req_rs1_i;
    logic [NrPorts*DataWidth-1:0]   req_rs2_i;
    logic [NrPorts*TransIdBits-1:0] req_trans_id_i;

    logic                           acc_req_valid_o;
    logic                           acc_req_ready_i;
    logic [InsnWidth-1:0]           acc_req_insn_o;
    logic [DataWidth-1:0]           acc_req_rs1_o;
    logic [DataWidth-1:0]           acc_req_rs2_o;
    logic [TransIdBits-1:0]         acc_req_trans_id_o;

    logic                           acc_resp_valid_i;
    logic                           acc_resp_ready_o;
    logic [TransIdBits-1:0]         acc_resp_trans_id_i;
    logic [DataWidth-1:0]           acc_resp_result_i;

    logic [NrPorts-1:0]             resp_valid_o;
    logic [NrPorts-1:0]             resp_ready_i;
    logic [TransIdBits-1:0]         resp_trans_id_o;
    logic [DataWidth-1:0]           resp_result_o;

    logic [CntW-1:0]                outstanding_o;
    logic                           orphan_resp_o;

    modport slave (
        input  req_valid_i, req_insn_i, req_rs1_i, req_rs2_i, req_trans_id_i,
        output req_ready_o,
        output acc_req_valid_o, acc_req_insn_o, acc_req_rs1_o, acc_req_rs2_o, acc_req_trans_id_o,
        input  acc_req_ready_i,
        input  acc_resp_valid_i, acc_resp_trans_id_i, acc_resp_result_i,
        output acc_resp_ready_o,
        output resp_valid_o, resp_trans_id_o, resp_result_o,
        input  resp_ready_i,
        output outstanding_o, orphan_resp_o
    );

    modport master (
        output req_valid_i, req_insn_i, req_rs1_i, req_rs2_i, req_trans_id_i,
        input  req_ready_o,
        input  acc_req_valid_o, acc_req_insn_o, acc_req_rs1_o, acc_req_rs2_o, acc_req_trans_id_o,
        output acc_req_ready_i,
        output acc_resp_valid_i, acc_resp_trans_id_i, acc_resp_result_i,
        input  acc_resp_ready_o,
        input  resp_valid_o, resp_trans_id_o, resp_result_o,
        output resp_ready_i,
        input  outstanding_o, orphan_resp_o
    );
endinterface

// File: rtl/acc_req_arbiter.sv
// Round-robin sharing of one accelerator port among NrPorts requesters; an
// in-order owner FIFO steers each response back to the port that issued it.
module acc_req_arbiter #(
    parameter int NrPorts        = 2,
    parameter int InsnWidth      = 32,
    parameter int DataWidth      = 64,
    parameter int TransIdBits    = 3,
    parameter int MaxOutstanding = 4
) (
    input  logic           clk_i,
    input  logic           rst_i,
    acc_req_arbiter_if.slave bus
);
    localparam int IdxW = $clog2(NrPorts);
    localparam int PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int CntW = $clog2(MaxOutstanding + 1);

    logic [InsnWidth-1:0]   insn_arr [NrPorts];
    logic [DataWidth-1:0]   rs1_arr  [NrPorts];
    logic [DataWidth-1:0]   rs2_arr  [NrPorts];
    logic [TransIdBits-1:0] tid_arr  [NrPorts];

    logic [IdxW-1:0]        rr_ptr_reg;
    logic [IdxW:0]          cand;
    logic                   grant_valid;
    logic [IdxW-1:0]        grant_idx;
    logic                   can_accept;
    logic                   push;
    logic                   pop;

    logic                   acc_valid_reg;
    logic [InsnWidth-1:0]   acc_insn_reg;
    logic [DataWidth-1:0]   acc_rs1_reg;
    logic [DataWidth-1:0]   acc_rs2_reg;
    logic [TransIdBits-1:0] acc_tid_reg;

    logic [IdxW-1:0]        owner_mem [MaxOutstanding];
    logic [PtrW-1:0]        wr_ptr_reg;
    logic [PtrW-1:0]        rd_ptr_reg;
    logic [CntW-1:0]        count_reg;
    logic                   orphan_reg;
    logic                   fifo_empty;
    logic [IdxW-1:0]        head_owner;

    genvar gi;
    generate
        for (gi = 0; gi < NrPorts; gi++) begin : g_port
            assign insn_arr[gi] = bus.req_insn_i[gi*InsnWidth +: InsnWidth];
            assign rs1_arr[gi]  = bus.req_rs1_i[gi*DataWidth +: DataWidth];
            assign rs2_arr[gi]  = bus.req_rs2_i[gi*DataWidth +: DataWidth];
            assign tid_arr[gi]  = bus.req_trans_id_i[gi*TransIdBits +: TransIdBits];
            assign bus.req_ready_o[gi]  = can_accept & grant_valid & (grant_idx == IdxW'(gi));
            assign bus.resp_valid_o[gi] = !fifo_empty & bus.acc_resp_valid_i & (head_owner == IdxW'(gi));
        end
    endgenerate

    // Scan offsets from highest to lowest so the requester nearest the pointer wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = NrPorts - 1; k >= 0; k--) begin
            cand = {1'b0, rr_ptr_reg} + (IdxW+1)'(k);
            if (cand >= (IdxW+1)'(NrPorts)) begin
                cand = cand - (IdxW+1)'(NrPorts);
            end
            if (bus.req_valid_i[cand[IdxW-1:0]]) begin
                grant_valid = 1'b1;
                grant_idx   = cand[IdxW-1:0];
            end
        end
    end

    assign fifo_empty = (count_reg == '0);
    assign head_owner = owner_mem[rd_ptr_reg];
    // Full blocks the push even when a pop happens in the same cycle.
    assign can_accept = (!acc_valid_reg | bus.acc_req_ready_i) & (count_reg < CntW'(MaxOutstanding));
    assign push       = grant_valid & can_accept;
    assign pop        = bus.acc_resp_valid_i & !fifo_empty & bus.resp_ready_i[head_owner];

    assign bus.acc_resp_ready_o   = fifo_empty | bus.resp_ready_i[head_owner];
    assign bus.resp_trans_id_o    = bus.acc_resp_trans_id_i;
    assign bus.resp_result_o      = bus.acc_resp_result_i;
    assign bus.acc_req_valid_o    = acc_valid_reg;
    assign bus.acc_req_insn_o     = acc_insn_reg;
    assign bus.acc_req_rs1_o      = acc_rs1_reg;
    assign bus.acc_req_rs2_o      = acc_rs2_reg;
    assign bus.acc_req_trans_id_o = acc_tid_reg;
    assign bus.outstanding_o      = count_reg;
    assign bus.orphan_resp_o      = orphan_reg;

    always_ff @(posedge clk_i) begin
        if (push) begin
            owner_mem[wr_ptr_reg] <= grant_idx;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr_reg    <= '0;
            acc_valid_reg <= 1'b0;
            acc_insn_reg  <= '0;
            acc_rs1_reg   <= '0;
            acc_rs2_reg   <= '0;
            acc_tid_reg   <= '0;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            orphan_reg    <= 1'b0;
        end else begin
            if (push) begin
                rr_ptr_reg    <= (grant_idx == IdxW'(NrPorts - 1)) ? '0 : grant_idx + 1'b1;
                acc_valid_reg <= 1'b1;
                acc_insn_reg  <= insn_arr[grant_idx];
                acc_rs1_reg   <= rs1_arr[grant_idx];
                acc_rs2_reg   <= rs2_arr[grant_idx];
                acc_tid_reg   <= tid_arr[grant_idx];
                wr_ptr_reg    <= (wr_ptr_reg == PtrW'(MaxOutstanding - 1)) ? '0 : wr_ptr_reg + 1'b1;
            end else if (bus.acc_req_ready_i) begin
                acc_valid_reg <= 1'b0;
            end
            if (pop) begin
                rd_ptr_reg <= (rd_ptr_reg == PtrW'(MaxOutstanding - 1)) ? '0 : rd_ptr_reg + 1'b1;
            end
            if (push && !pop) begin
                count_reg <= count_reg + 1'b1;
            end else if (!push && pop) begin
                count_reg <= count_reg - 1'b1;
            end
            if (bus.acc_resp_valid_i && fifo_empty) begin
                orphan_reg <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_acc_req_arbiter.sv
// Directed bench for acc_req_arbiter with two requesters and a 4-deep owner FIFO.
module tb_acc_req_arbiter;
    localparam int NrPorts        = 2;
    localparam int InsnWidth      = 32;
    localparam int DataWidth      = 64;
    localparam int TransIdBits    = 3;
    localparam int MaxOutstanding = 4;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    acc_req_arbiter_if #(
        .NrPorts(NrPorts), .InsnWidth(InsnWidth), .DataWidth(DataWidth),
        .TransIdBits(TransIdBits), .MaxOutstanding(MaxOutstanding)
    ) bus ();

    acc_req_arbiter #(
        .NrPorts(NrPorts), .InsnWidth(InsnWidth), .DataWidth(DataWidth),
        .TransIdBits(TransIdBits), .MaxOutstanding(MaxOutstanding)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end else begin
            $display("ok   %s: %0h", tag, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int p, input logic [31:0] insn, input logic [63:0] rs1,
                            input logic [63:0] rs2, input logic [2:0] tid);
        bus.req_insn_i[p*InsnWidth +: InsnWidth]           = insn;
        bus.req_rs1_i[p*DataWidth +: DataWidth]            = rs1;
        bus.req_rs2_i[p*DataWidth +: DataWidth]            = rs2;
        bus.req_trans_id_i[p*TransIdBits +: TransIdBits]   = tid;
    endtask

    logic [1:0] exp_owner [4];

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        bus.req_valid_i         = '0;
        bus.req_insn_i          = '0;
        bus.req_rs1_i           = '0;
        bus.req_rs2_i           = '0;
        bus.req_trans_id_i      = '0;
        bus.acc_req_ready_i     = 1'b0;
        bus.acc_resp_valid_i    = 1'b0;
        bus.acc_resp_trans_id_i = '0;
        bus.acc_resp_result_i   = '0;
        bus.resp_ready_i        = '0;
        tick();
        tick();
        check_eq("rst_acc_valid", 64'(bus.acc_req_valid_o), 64'd0);
        check_eq("rst_outstanding", 64'(bus.outstanding_o), 64'd0);
        check_eq("rst_orphan", 64'(bus.orphan_resp_o), 64'd0);
        check_eq("rst_insn", 64'(bus.acc_req_insn_o), 64'd0);
        rst = 1'b0;

        // Both ports busy, responses withheld: grants alternate until the FIFO fills.
        set_port(0, 32'h1111_0000, 64'h10, 64'h100, 3'd1);
        set_port(1, 32'h2222_0000, 64'h20, 64'h200, 3'd2);
        bus.req_valid_i     = 2'b11;
        bus.acc_req_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check_eq($sformatf("fill_ready_%0d", i), 64'(bus.req_ready_o), (i % 2 == 0) ? 64'd1 : 64'd2);
            tick();
            check_eq($sformatf("fill_tid_%0d", i), 64'(bus.acc_req_trans_id_o), (i % 2 == 0) ? 64'd1 : 64'd2);
            check_eq($sformatf("fill_cnt_%0d", i), 64'(bus.outstanding_o), 64'(i + 1));
        end
        #1;
        check_eq("full_ready", 64'(bus.req_ready_o), 64'd0);
        check_eq("full_cnt", 64'(bus.outstanding_o), 64'd4);

        // Full with a simultaneous response pop: push stays blocked this cycle.
        bus.req_valid_i       = 2'b01;
        bus.acc_resp_valid_i  = 1'b1;
        bus.acc_resp_result_i = 64'hAAAA;
        bus.resp_ready_i      = 2'b11;
        #1;
        check_eq("fullpop_req_ready", 64'(bus.req_ready_o), 64'd0);
        check_eq("fullpop_resp_valid", 64'(bus.resp_valid_o), 64'd1);
        check_eq("fullpop_acc_resp_ready", 64'(bus.acc_resp_ready_o), 64'd1);
        tick();
        check_eq("fullpop_cnt", 64'(bus.outstanding_o), 64'd3);
        check_eq("fullpop_drained", 64'(bus.acc_req_valid_o), 64'd0);
        bus.acc_resp_valid_i = 1'b0;
        #1;
        check_eq("afterpop_ready", 64'(bus.req_ready_o), 64'd1);
        tick();
        check_eq("afterpop_cnt", 64'(bus.outstanding_o), 64'd4);
        check_eq("afterpop_rs1", 64'(bus.acc_req_rs1_o), 64'h10);

        // Head owner 1 not ready for two cycles: FIFO must hold.
        bus.req_valid_i       = 2'b00;
        bus.acc_resp_valid_i  = 1'b1;
        bus.acc_resp_result_i = 64'hBBBB;
        bus.resp_ready_i      = 2'b01;
        for (int i = 0; i < 2; i++) begin
            #1;
            check_eq($sformatf("stallresp_valid_%0d", i), 64'(bus.resp_valid_o), 64'd2);
            check_eq($sformatf("stallresp_ready_%0d", i), 64'(bus.acc_resp_ready_o), 64'd0);
            tick();
            check_eq($sformatf("stallresp_cnt_%0d", i), 64'(bus.outstanding_o), 64'd4);
        end
        bus.resp_ready_i = 2'b11;
        #1;
        check_eq("release_ready", 64'(bus.acc_resp_ready_o), 64'd1);
        check_eq("release_result", 64'(bus.resp_result_o), 64'hBBBB);
        tick();
        bus.acc_resp_valid_i = 1'b0;
        check_eq("release_cnt", 64'(bus.outstanding_o), 64'd3);
        tick();
        check_eq("release_once", 64'(bus.outstanding_o), 64'd3);

        // Pop owner 0 to leave room for the backpressure test.
        bus.acc_resp_valid_i  = 1'b1;
        bus.acc_resp_result_i = 64'hCCCC;
        #1;
        check_eq("pop0_valid", 64'(bus.resp_valid_o), 64'd1);
        tick();
        bus.acc_resp_valid_i = 1'b0;
        check_eq("pop0_cnt", 64'(bus.outstanding_o), 64'd2);

        // Backpressure: port-1 payload must hold for three stalled cycles.
        set_port(1, 32'h2222_0005, 64'h25, 64'h205, 3'd5);
        bus.req_valid_i     = 2'b10;
        bus.acc_req_ready_i = 1'b0;
        #1;
        check_eq("bp_first_ready", 64'(bus.req_ready_o), 64'd2);
        tick();
        check_eq("bp_loaded_valid", 64'(bus.acc_req_valid_o), 64'd1);
        set_port(1, 32'h2222_0006, 64'h26, 64'h206, 3'd6);
        for (int i = 0; i < 3; i++) begin
            #1;
            check_eq($sformatf("bp_stall_ready_%0d", i), 64'(bus.req_ready_o), 64'd0);
            tick();
            check_eq($sformatf("bp_stall_tid_%0d", i), 64'(bus.acc_req_trans_id_o), 64'd5);
            check_eq($sformatf("bp_stall_insn_%0d", i), 64'(bus.acc_req_insn_o), 64'h2222_0005);
            check_eq($sformatf("bp_stall_valid_%0d", i), 64'(bus.acc_req_valid_o), 64'd1);
        end
        bus.acc_req_ready_i = 1'b1;
        #1;
        check_eq("bp_refill_ready", 64'(bus.req_ready_o), 64'd2);
        tick();
        check_eq("bp_refill_tid", 64'(bus.acc_req_trans_id_o), 64'd6);
        check_eq("bp_refill_cnt", 64'(bus.outstanding_o), 64'd4);
        bus.req_valid_i = 2'b00;

        // Owners now queued in issue order 1,0,1,1.
        exp_owner[0] = 2'b10;
        exp_owner[1] = 2'b01;
        exp_owner[2] = 2'b10;
        exp_owner[3] = 2'b10;
        bus.resp_ready_i     = 2'b11;
        bus.acc_resp_valid_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.acc_resp_result_i   = 64'hD000 + 64'(i);
            bus.acc_resp_trans_id_i = 3'(i + 1);
            #1;
            check_eq($sformatf("resp_valid_%0d", i), 64'(bus.resp_valid_o), 64'(exp_owner[i]));
            check_eq($sformatf("resp_result_%0d", i), 64'(bus.resp_result_o), 64'hD000 + 64'(i));
            check_eq($sformatf("resp_tid_%0d", i), 64'(bus.resp_trans_id_o), 64'(i + 1));
            tick();
            check_eq($sformatf("resp_cnt_%0d", i), 64'(bus.outstanding_o), 64'(3 - i));
        end

        // Orphan response with the FIFO empty.
        bus.resp_ready_i = 2'b00;
        #1;
        check_eq("orphan_resp_valid", 64'(bus.resp_valid_o), 64'd0);
        check_eq("orphan_acc_ready", 64'(bus.acc_resp_ready_o), 64'd1);
        tick();
        bus.acc_resp_valid_i = 1'b0;
        check_eq("orphan_set", 64'(bus.orphan_resp_o), 64'd1);
        tick();
        check_eq("orphan_sticky", 64'(bus.orphan_resp_o), 64'd1);

        // Two outstanding with the pointer left at 1, then reset.
        bus.req_valid_i = 2'b10;
        tick();
        bus.req_valid_i = 2'b01;
        tick();
        bus.req_valid_i = 2'b00;
        check_eq("prerst_cnt", 64'(bus.outstanding_o), 64'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("postrst_cnt", 64'(bus.outstanding_o), 64'd0);
        check_eq("postrst_acc_valid", 64'(bus.acc_req_valid_o), 64'd0);
        check_eq("postrst_orphan", 64'(bus.orphan_resp_o), 64'd0);
        check_eq("postrst_tid", 64'(bus.acc_req_trans_id_o), 64'd0);
        bus.req_valid_i      = 2'b11;
        bus.acc_resp_valid_i = 1'b1;
        bus.resp_ready_i     = 2'b11;
        #1;
        check_eq("postrst_grant", 64'(bus.req_ready_o), 64'd1);
        check_eq("postrst_resp_valid", 64'(bus.resp_valid_o), 64'd0);
        check_eq("postrst_acc_resp_ready", 64'(bus.acc_resp_ready_o), 64'd1);
        bus.req_valid_i      = 2'b00;
        bus.acc_resp_valid_i = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
